// File: rtl/pc_target_table.sv
// Programmable branch-target table: ENTRIES x D-bit targets, swept to zero after reset or clr,
// with registered one-cycle reads and a write-first bypass for same-cycle write/read collisions.
module pc_target_table #(
    parameter int D       = 12,
    parameter int A       = 8,
    parameter int ENTRIES = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    output logic         busy,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         rd_en,
    input  logic [A-1:0] rd_addr,
    output logic [D-1:0] rd_target,
    output logic         rd_valid
);

    localparam int           IDX_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [A:0]   ENTRIES_W = ENTRIES[A:0];
    localparam logic [A:0]   LAST_PTR  = ENTRIES_W - 1'b1;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [A:0]         ptr, ptr_nxt;
    logic [D-1:0]       mem [ENTRIES];

    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [D-1:0]       mem_wdata;
    logic               rd_fire;
    logic [D-1:0]       rd_data_nxt;
    logic               wr_in_range;
    logic               rd_in_range;

    // A zero-extended address compare keeps out-of-range indices from aliasing onto real entries.
    assign wr_in_range = ({1'b0, wr_addr} < ENTRIES_W);
    assign rd_in_range = ({1'b0, rd_addr} < ENTRIES_W);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        mem_we      = 1'b0;
        mem_waddr   = ptr[IDX_W-1:0];
        mem_wdata   = '0;
        rd_fire     = 1'b0;
        rd_data_nxt = rd_target;
        case (state)
            INIT: begin
                mem_we = 1'b1;
                if (clr) begin
                    ptr_nxt = '0;
                end else if (ptr == LAST_PTR) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_nxt = INIT;
                    ptr_nxt   = '0;
                end else begin
                    if (wr_en && wr_in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = wr_addr[IDX_W-1:0];
                        mem_wdata = wr_data;
                    end
                    if (rd_en) begin
                        rd_fire = 1'b1;
                        if (!rd_in_range) begin
                            rd_data_nxt = '0;
                        end else if (wr_en && (wr_addr == rd_addr)) begin
                            rd_data_nxt = wr_data;
                        end else begin
                            rd_data_nxt = mem[rd_addr[IDX_W-1:0]];
                        end
                    end
                end
            end
            default: begin
                state_nxt = INIT;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Control and read-result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            ptr       <= '0;
            busy      <= 1'b1;
            rd_valid  <= 1'b0;
            rd_target <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            busy     <= (state_nxt == INIT);
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_target <= rd_data_nxt;
            end
        end
    end

    // Storage is left unreset so it maps onto plain RAM; the sweep provides the cleared state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_pc_target_table.sv
// Self-checking bench for pc_target_table: directed vector table, clear/reset sequences,
// and randomized traffic against an array-based reference model.
module tb_pc_target_table;

    localparam int D = 12;
    localparam int A = 8;
    localparam int N = 32;

    logic         clk;
    logic         reset_n;
    logic         clr;
    logic         busy;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         rd_en;
    logic [A-1:0] rd_addr;
    logic [D-1:0] rd_target;
    logic         rd_valid;

    pc_target_table #(.D(D), .A(A), .ENTRIES(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clr),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_target (rd_target),
        .rd_valid  (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [A-1:0] wa;
        logic [D-1:0] wd;
        logic         re;
        logic [A-1:0] ra;
        logic         ev;
        logic [D-1:0] et;
    } vec_t;

    vec_t vecs[14];
    int   mdl[N];
    int   last_tgt;
    int   errors;
    int   checks;
    int   n;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Counts edges until busy drops; reads are held high the whole time and must be ignored.
    task automatic sweep_count(input string tag, output int cnt);
        cnt   = 0;
        rd_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            cnt++;
            check({tag, "_rdv_during_sweep"}, int'(rd_valid), 0);
            check({tag, "_hold_during_sweep"}, int'(rd_target), last_tgt);
            if (!busy) break;
        end
        rd_en = 1'b0;
        for (int i = 0; i < N; i++) mdl[i] = 0;
    endtask

    task automatic do_cycle(input logic we, input logic [A-1:0] wa, input logic [D-1:0] wd,
                            input logic re, input logic [A-1:0] ra, input string tag);
        int exp;
        exp = last_tgt;
        if (re) begin
            if (int'(ra) >= N) exp = 0;
            else if (we && wa == ra) exp = int'(wd);
            else exp = mdl[int'(ra)];
        end
        if (we && int'(wa) < N) mdl[int'(wa)] = int'(wd);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra;
        step();
        idle_inputs();
        check({tag, "_valid"}, int'(rd_valid), int'(re));
        check({tag, "_target"}, int'(rd_target), exp);
        last_tgt = exp;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        last_tgt = 0;
        for (int i = 0; i < N; i++) mdl[i] = 0;

        vecs[0]  = '{1'b1, 8'd0,  12'd7,    1'b0, 8'd0,  1'b0, 12'd0};
        vecs[1]  = '{1'b1, 8'd1,  12'd8,    1'b0, 8'd0,  1'b0, 12'd0};
        vecs[2]  = '{1'b1, 8'd2,  12'd285,  1'b0, 8'd0,  1'b0, 12'd0};
        vecs[3]  = '{1'b1, 8'd3,  12'd267,  1'b0, 8'd0,  1'b0, 12'd0};
        vecs[4]  = '{1'b0, 8'd0,  12'd0,    1'b1, 8'd0,  1'b1, 12'd7};
        vecs[5]  = '{1'b0, 8'd0,  12'd0,    1'b1, 8'd1,  1'b1, 12'd8};
        vecs[6]  = '{1'b0, 8'd0,  12'd0,    1'b1, 8'd2,  1'b1, 12'd285};
        vecs[7]  = '{1'b0, 8'd0,  12'd0,    1'b1, 8'd3,  1'b1, 12'd267};
        vecs[8]  = '{1'b1, 8'd5,  12'd375,  1'b1, 8'd5,  1'b1, 12'd375};
        vecs[9]  = '{1'b0, 8'd0,  12'd0,    1'b0, 8'd0,  1'b0, 12'd375};
        vecs[10] = '{1'b1, 8'd40, 12'hFFF,  1'b0, 8'd0,  1'b0, 12'd375};
        vecs[11] = '{1'b0, 8'd0,  12'd0,    1'b1, 8'd40, 1'b1, 12'd0};
        vecs[12] = '{1'b0, 8'd0,  12'd0,    1'b1, 8'd8,  1'b1, 12'd0};
        vecs[13] = '{1'b0, 8'd0,  12'd0,    1'b1, 8'd5,  1'b1, 12'd375};

        reset_n = 1'b0;
        idle_inputs();
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        #12;
        check("reset_busy", int'(busy), 1);
        check("reset_rd_valid", int'(rd_valid), 0);
        check("reset_rd_target", int'(rd_target), 0);

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        sweep_count("init", n);
        check("init_sweep_len", n, N);

        for (int i = 0; i < N; i++) do_cycle(1'b0, '0, '0, 1'b1, 8'(i), "zero_read");

        for (int i = 0; i < 14; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rd_en = vecs[i].re; rd_addr = vecs[i].ra;
            if (vecs[i].we && int'(vecs[i].wa) < N) mdl[int'(vecs[i].wa)] = int'(vecs[i].wd);
            step();
            idle_inputs();
            check($sformatf("vec%0d_valid", i), int'(rd_valid), int'(vecs[i].ev));
            check($sformatf("vec%0d_target", i), int'(rd_target), int'(vecs[i].et));
            last_tgt = int'(vecs[i].et);
        end

        for (int i = 0; i < 300; i++) begin
            logic         we, re;
            logic [A-1:0] wa, ra;
            logic [D-1:0] wd;
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = 8'($urandom_range(0, 47));
            ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 47));
            wd = 12'($urandom);
            do_cycle(we, wa, wd, re, ra, "rnd");
        end

        // clr pulse that also carries a write and read: both must be suppressed.
        do_cycle(1'b1, 8'd2, 12'd285, 1'b0, '0, "prog2");
        clr = 1'b1; wr_en = 1'b1; wr_addr = 8'd2; wr_data = 12'd999;
        rd_en = 1'b1; rd_addr = 8'd2;
        step();
        idle_inputs();
        check("clr_busy", int'(busy), 1);
        check("clr_rd_valid", int'(rd_valid), 0);
        sweep_count("clr", n);
        check("clr_sweep_len", n, N);
        do_cycle(1'b0, '0, '0, 1'b1, 8'd2, "after_clr");
        check("after_clr_entry2_zero", int'(rd_target), 0);

        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("restart_busy_mid", int'(busy), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        sweep_count("restart", n);
        check("restart_sweep_len", n, N);

        do_cycle(1'b1, 8'd5, 12'd375, 1'b1, 8'd5, "pre_rst");
        reset_n = 1'b0;
        #1;
        check("midread_rst_busy", int'(busy), 1);
        check("midread_rst_rd_valid", int'(rd_valid), 0);
        check("midread_rst_rd_target", int'(rd_target), 0);
        last_tgt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset_n = 1'b0;
        #1;
        check("midsweep_rst_busy", int'(busy), 1);
        check("midsweep_rst_rd_valid", int'(rd_valid), 0);
        check("midsweep_rst_rd_target", int'(rd_target), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        sweep_count("rst", n);
        check("rst_sweep_len", n, N);
        do_cycle(1'b0, '0, '0, 1'b1, 8'd5, "after_rst");
        do_cycle(1'b1, 8'd31, 12'd123, 1'b0, '0, "last_wr");
        do_cycle(1'b0, '0, '0, 1'b1, 8'd31, "last_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
